// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and fetch-buffer state encoding for the MIPS fetch stage
//
// Purpose: single home for the fetch-stage defaults (reset PC, bubble instruction),
//          the instruction word size in bytes and the buffer state enum.
// Contents:
//   RESET_PC_DEFAULT   default PC after reset
//   NOP_INSTR_DEFAULT  default bubble instruction (sll $0,$0,0)
//   WORD_BYTES         PC increment per instruction
//   fetch_state_e      EMPTY = buffer free, FULL = buffer holds an instruction

package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES        = 32'd4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/mips_pc_npc_reg.sv
// rtl/mips_pc_npc_reg.sv - PC/nPC register pair implementing the MIPS delayed-branch model
//
// Purpose: holds the fetch PC and the address that follows it. A branch either
//          replaces both (delay slot already fetched) or only nPC (delay slot
//          still waiting at PC).
// Ports:
//   Clk, Reset     clock, synchronous active-high reset
//   advance        PC <= nPC, nPC <= nPC+4 (a word was accepted)
//   redirect_now   PC <= target, nPC <= target+4
//   redirect_next  nPC <= target, PC unchanged
//   target         word-aligned redirect address
//   pc             current fetch address

module mips_pc_npc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        advance,
  input  logic        redirect_now,
  input  logic        redirect_next,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] npc;

  // Additions wrap modulo 2^32, so 32'hFFFF_FFFC steps to 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc  <= RESET_PC;
      npc <= RESET_PC + WORD_BYTES;
    end else if (redirect_now) begin
      pc  <= target;
      npc <= target + WORD_BYTES;
    end else if (redirect_next) begin
      npc <= target;
    end else if (advance) begin
      pc  <= npc;
      npc <= npc + WORD_BYTES;
    end
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// rtl/mips_fetch_stage.sv - instruction fetch stage feeding the IF/ID register
//
// Purpose: fetches instructions through a req/ack memory handshake, buffers one
//          word until IF/ID loads it, and applies branch/jump redirects from ID
//          with a delay slot that always executes.
// Ports:
//   Clk, Reset                       clock, synchronous active-high reset
//   LE                               IF/ID load enable (0 = stall)
//   Redirect_Valid, Redirect_Target  taken branch/jump from ID (target bits [1:0] ignored)
//   Imem_Req, Imem_Addr              fetch request and word address (= PC)
//   Imem_Ack, Imem_Data              memory returns a word this cycle
//   IF_Valid, IF_Instr, IF_PC        buffered instruction towards IF/ID

module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LE,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  output logic        IF_Valid,
  output logic [31:0] IF_Instr,
  output logic [31:0] IF_PC
);

  fetch_state_e state_q, state_d;
  logic         consume, redirect, accept;
  logic         advance, redirect_now, redirect_next;
  logic [31:0]  pc, target, instr_q, if_pc_q;

  assign target = Redirect_Target & ~32'h3;

  mips_pc_npc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_npc (
    .Clk          (Clk),
    .Reset        (Reset),
    .advance      (advance),
    .redirect_now (redirect_now),
    .redirect_next(redirect_next),
    .target       (target),
    .pc           (pc)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    consume       = 1'b0;
    redirect      = 1'b0;
    Imem_Req      = 1'b0;
    accept        = 1'b0;
    advance       = 1'b0;
    redirect_now  = 1'b0;
    redirect_next = 1'b0;

    consume  = (state_q == FULL) && LE;
    // Redirects only count on cycles where IF/ID actually loads.
    redirect = Redirect_Valid && LE;
    // A redirect while FULL means the buffered word is the delay slot; the
    // word at PC is on the wrong path, so no fetch that cycle.
    Imem_Req = !Reset && ((state_q == EMPTY) || consume) && !(redirect && (state_q == FULL));
    accept   = Imem_Req && Imem_Ack;

    if (accept) begin
      state_d = FULL;
    end else if (consume) begin
      state_d = EMPTY;
    end

    // Delay slot already in hand (buffered or accepted now): jump PC to target.
    // Delay slot still at PC: only the address after it changes.
    redirect_now  = redirect && ((state_q == FULL) || accept);
    redirect_next = redirect && (state_q == EMPTY) && !accept;
    advance       = accept && !redirect;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      instr_q <= NOP_INSTR;
      if_pc_q <= 32'h0;
    end else if (accept) begin
      instr_q <= Imem_Data;
      if_pc_q <= pc;
    end
  end

  assign Imem_Addr = pc;
  assign IF_Valid  = (state_q == FULL);
  assign IF_Instr  = IF_Valid ? instr_q : NOP_INSTR;
  assign IF_PC     = IF_Valid ? if_pc_q : 32'h0;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb/tb_mips_fetch_stage.sv - self-checking bench for mips_fetch_stage

module tb_mips_fetch_stage;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        le = 1'b0;
  logic        ack = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rt = 32'h0;

  logic        imem_req, imem_req_w;
  logic [31:0] imem_addr, imem_addr_w, imem_data, imem_data_w;
  logic        if_valid, if_valid_w;
  logic [31:0] if_instr, if_instr_w, if_pc, if_pc_w;

  int checks = 0;
  int errors = 0;

  // Reference model state: fetch address, following address, buffer contents.
  logic [31:0] m_pc = 32'h0, m_npc = 32'h4, m_instr = 32'h0, m_ifpc = 32'h0;
  logic        m_full = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_data   = mem_word(imem_addr);
  assign imem_data_w = mem_word(imem_addr_w);

  mips_fetch_stage dut (
    .Clk(clk), .Reset(reset), .LE(le), .Redirect_Valid(rv), .Redirect_Target(rt),
    .Imem_Req(imem_req), .Imem_Addr(imem_addr), .Imem_Ack(ack), .Imem_Data(imem_data),
    .IF_Valid(if_valid), .IF_Instr(if_instr), .IF_PC(if_pc)
  );

  mips_fetch_stage #(.RESET_PC(WRAP_PC), .NOP_INSTR(32'h0)) dut_w (
    .Clk(clk), .Reset(reset), .LE(le), .Redirect_Valid(rv), .Redirect_Target(rt),
    .Imem_Req(imem_req_w), .Imem_Addr(imem_addr_w), .Imem_Ack(ack), .Imem_Data(imem_data_w),
    .IF_Valid(if_valid_w), .IF_Instr(if_instr_w), .IF_PC(if_pc_w)
  );

  // A fetch is requested when the buffer is (or becomes) free, except when a
  // branch resolves while the buffer holds its delay slot.
  function automatic logic model_req();
    return !reset && (!m_full || le) && !(rv && le && m_full);
  endfunction

  task automatic model_update();
    logic        acc, redir, had_slot;
    logic [31:0] tgt;
    if (reset) begin
      m_pc = 32'h0; m_npc = 32'h4; m_full = 1'b0;
      return;
    end
    acc      = model_req() && ack;
    redir    = rv && le;
    tgt      = {rt[31:2], 2'b00};
    had_slot = m_full || acc;
    if (acc) begin
      m_instr = mem_word(m_pc);
      m_ifpc  = m_pc;
      m_full  = 1'b1;
    end else if (m_full && le) begin
      m_full = 1'b0;
    end
    if (redir && had_slot) begin
      m_pc = tgt; m_npc = tgt + 32'd4;
    end else if (redir) begin
      m_npc = tgt;
    end else if (acc) begin
      m_pc = m_npc; m_npc = m_npc + 32'd4;
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic a, input logic v,
                       input logic [31:0] t);
    reset = r; le = l; ack = a; rv = v; rt = t;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 0, 0);
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
    step(); step();
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", if_valid); end
    checks++;
    if (if_instr !== 32'h0 || if_pc !== 32'h0) begin
      errors++; $display("FAIL reset_outs instr %h pc %h want 0 0", if_instr, if_pc);
    end
    checks++;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_sequential_fetch();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
        errors++; $display("FAIL seq_addr%0d req %0b addr %h want 1 %h", i, imem_req, imem_addr, 32'(i * 4));
      end
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_instr !== mem_word(32'(i * 4))) begin
        errors++; $display("FAIL seq_if%0d valid %0b pc %h instr %h want pc %h", i, if_valid, if_pc, if_instr, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = if_instr;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0);
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 32'd12) begin
        errors++; $display("FAIL stall_req%0d req %0b addr %h want 0 0000000c", i, imem_req, imem_addr);
      end
      step();
      checks++;
      if (if_pc !== 32'd8 || if_instr !== held || if_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d pc %h instr %h want 00000008 %h", i, if_pc, if_instr, held);
      end
    end
    drive(0, 1, 1, 0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd12) begin
      errors++; $display("FAIL stall_resume req %0b addr %h want 1 0000000c", imem_req, imem_addr);
    end
    step();
    checks++;
    if (if_pc !== 32'd12) begin errors++; $display("FAIL stall_resume_pc got %h want 0000000c", if_pc); end
  endtask

  task automatic test_redirect_full();
    drive(0, 1, 1, 0, 0); step();
    drive(0, 1, 1, 0, 0); step();
    checks++;
    if (if_pc !== 32'h14 || imem_addr !== 32'h18) begin
      errors++; $display("FAIL rfull_setup pc %h addr %h want 00000014 00000018", if_pc, imem_addr);
    end
    drive(0, 1, 1, 1, 32'h0000_0100);
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rfull_nofetch req %0b want 0", imem_req); end
    step();
    checks++;
    if (if_valid !== 1'b0 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL rfull_target valid %0b addr %h want 0 00000100", if_valid, imem_addr);
    end
    drive(0, 1, 1, 0, 0); step();
    checks++;
    if (if_pc !== 32'h100 || imem_addr !== 32'h104) begin
      errors++; $display("FAIL rfull_next pc %h addr %h want 00000100 00000104", if_pc, imem_addr);
    end
  endtask

  task automatic test_redirect_empty();
    drive(1, 1, 1, 0, 0); step();
    for (int i = 0; i < 5; i++) begin drive(0, 1, 1, 0, 0); step(); end
    drive(0, 1, 0, 0, 0); step();
    drive(0, 1, 0, 1, 32'h0000_0203);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      errors++; $display("FAIL rempty_req req %0b addr %h want 1 00000014", imem_req, imem_addr);
    end
    step();
    drive(0, 1, 0, 0, 0); step();
    checks++;
    if (imem_addr !== 32'h14 || if_valid !== 1'b0) begin
      errors++; $display("FAIL rempty_slot addr %h valid %0b want 00000014 0", imem_addr, if_valid);
    end
    drive(0, 1, 1, 0, 0); step();
    checks++;
    if (if_pc !== 32'h14 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL rempty_target pc %h addr %h want 00000014 00000200", if_pc, imem_addr);
    end
    drive(0, 1, 1, 0, 0); step();
    checks++;
    if (if_pc !== 32'h200 || imem_addr !== 32'h204) begin
      errors++; $display("FAIL rempty_next pc %h addr %h want 00000200 00000204", if_pc, imem_addr);
    end
  endtask

  task automatic test_ack_latency();
    drive(0, 1, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h204 || if_valid !== 1'b0 || if_instr !== 32'h0) begin
        errors++; $display("FAIL latency_wait%0d req %0b addr %h valid %0b instr %h want 1 00000204 0 0",
                           i, imem_req, imem_addr, if_valid, if_instr);
      end
      step();
    end
    drive(0, 1, 1, 0, 0);
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL latency_ackcycle valid %0b want 0", if_valid); end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h204 || if_instr !== mem_word(32'h204)) begin
      errors++; $display("FAIL latency_after valid %0b pc %h instr %h want 1 00000204", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_wrap_and_reset_drop();
    drive(1, 1, 1, 0, 0); step(); step();
    drive(0, 1, 1, 0, 0);
    checks++;
    if (imem_req_w !== 1'b1 || imem_addr_w !== WRAP_PC) begin
      errors++; $display("FAIL wrap_first req %0b addr %h want 1 fffffffc", imem_req_w, imem_addr_w);
    end
    step();
    checks++;
    if (if_pc_w !== WRAP_PC || if_instr_w !== mem_word(WRAP_PC) || imem_addr_w !== 32'h0) begin
      errors++; $display("FAIL wrap_next pc %h instr %h addr %h want fffffffc %h 0", if_pc_w, if_instr_w, imem_addr_w, mem_word(WRAP_PC));
    end
    drive(1, 1, 1, 0, 0);
    checks++;
    if (imem_req_w !== 1'b0) begin errors++; $display("FAIL wrap_reset_req got %0b want 0", imem_req_w); end
    step();
    checks++;
    if (if_valid_w !== 1'b0 || imem_addr_w !== WRAP_PC || if_pc_w !== 32'h0) begin
      errors++; $display("FAIL wrap_reset_drop valid %0b addr %h pc %h want 0 fffffffc 0", if_valid_w, imem_addr_w, if_pc_w);
    end
  endtask

  task automatic test_random();
    logic r, l, a, v;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 2) != 0);
      v = l && ($urandom_range(0, 5) == 0);
      drive(r, l, a, v, $urandom);
      checks++;
      if (imem_req !== model_req() || imem_addr !== m_pc) begin
        errors++; $display("FAIL rand_fetch%0d req %0b addr %h want %0b %h", i, imem_req, imem_addr, model_req(), m_pc);
      end
      step();
      checks++;
      if (if_valid !== m_full || if_instr !== (m_full ? m_instr : 32'h0) || if_pc !== (m_full ? m_ifpc : 32'h0)) begin
        errors++; $display("FAIL rand_if%0d valid %0b instr %h pc %h want %0b %h %h", i, if_valid, if_instr, if_pc,
                           m_full, m_full ? m_instr : 32'h0, m_full ? m_ifpc : 32'h0);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential_fetch();
    test_stall();
    test_redirect_full();
    test_redirect_empty();
    test_ack_latency();
    test_wrap_and_reset_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
